intr_ctrl: RTL and testbench

Parametrised interrupt controller for the RAT CPU. Each of N_CH sources is latched into a pending bit, either on a rising edge or as a level, and gated by a software mask. The highest-priority enabled request is presented to the CPU as a single request line plus a channel ID. An ACK/RETI handshake clears the serviced channel and blocks nesting until the interrupt service routine returns.

---
 rtl/intr_ctrl.sv | 121 ++++++++++++
 tb/tb_intr_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge/level capture into pending bits, software mask,
// fixed priority (channel 0 highest), and a non-nesting ACK/RETI handshake.
module intr_ctrl #(
    parameter int                N_CH      = 8,
    parameter int                ID_W      = 3,
    parameter logic [N_CH-1:0]   EDGE_MASK = {N_CH{1'b1}}
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic [N_CH-1:0]   I_SRC,
    input  logic              I_MASK_WE,
    input  logic [N_CH-1:0]   I_MASK_IN,
    input  logic [N_CH-1:0]   I_SW_CLR,
    input  logic              I_ACK,
    input  logic              I_RETI,
    output logic              I_OUT,
    output logic [ID_W-1:0]   I_ID,
    output logic [N_CH-1:0]   I_PEND,
    output logic [N_CH-1:0]   I_MASK
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   prev_q, prev_d;
    logic [ID_W-1:0]   svc_id_q, svc_id_d;

    logic [N_CH-1:0]   ev_s;
    logic [N_CH-1:0]   active_s;
    logic [N_CH-1:0]   ack_clr_s;
    logic [ID_W-1:0]   sel_s;
    logic              out_s;
    logic [ID_W-1:0]   id_s;

    // Event detection and lowest-index priority select over enabled pending bits.
    always_comb begin
        ev_s     = (EDGE_MASK & I_SRC & ~prev_q) | (~EDGE_MASK & I_SRC);
        active_s = pend_q & mask_q;
        sel_s    = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (active_s[i]) begin
                sel_s = ID_W'(i);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Handshake FSM: request/ID outputs and the ACK-driven pending clear.
    always_comb begin
        state_d   = state_q;
        svc_id_d  = svc_id_q;
        ack_clr_s = '0;
        out_s     = 1'b0;
        id_s      = '0;
        case (state_q)
            IDLE: begin
                out_s = |active_s;
                id_s  = sel_s;
                if (I_ACK && out_s) begin
                    ack_clr_s[sel_s] = 1'b1;
                    svc_id_d         = sel_s;
                    state_d          = SERVICE;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                id_s = svc_id_q;
                if (I_RETI) begin
                    state_d = IDLE;
                end else begin
                    state_d = SERVICE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values for pending (set wins over clear), mask and source history.
    always_comb begin
        pend_d = ev_s | (pend_q & ~(I_SW_CLR | ack_clr_s));
        prev_d = I_SRC;
        if (I_MASK_WE) begin
            mask_d = I_MASK_IN;
        end else begin
            mask_d = mask_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            mask_q   <= '0;
            prev_q   <= '0;
            svc_id_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            prev_q   <= prev_d;
            svc_id_q <= svc_id_d;
        end
    end

    assign I_OUT  = out_s;
    assign I_ID   = id_s;
    assign I_PEND = pend_q;
    assign I_MASK = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed walk through the controller's handshake and capture rules, then a
// randomized run checked every cycle against a behavioural reference model.
module tb_intr_ctrl;

    localparam logic [7:0] EDGE_CFG = 8'hFD;   // channel 1 is level-captured

    logic       I_CLK;
    logic       I_RST;
    logic [7:0] I_SRC;
    logic       I_MASK_WE;
    logic [7:0] I_MASK_IN;
    logic [7:0] I_SW_CLR;
    logic       I_ACK;
    logic       I_RETI;
    logic       I_OUT;
    logic [2:0] I_ID;
    logic [7:0] I_PEND;
    logic [7:0] I_MASK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_prev [8];
    bit m_pend [8];
    bit m_mask [8];
    bit m_busy;
    int m_svc;

    intr_ctrl #(
        .N_CH      (8),
        .ID_W      (3),
        .EDGE_MASK (EDGE_CFG)
    ) dut (
        .I_CLK     (I_CLK),
        .I_RST     (I_RST),
        .I_SRC     (I_SRC),
        .I_MASK_WE (I_MASK_WE),
        .I_MASK_IN (I_MASK_IN),
        .I_SW_CLR  (I_SW_CLR),
        .I_ACK     (I_ACK),
        .I_RETI    (I_RETI),
        .I_OUT     (I_OUT),
        .I_ID      (I_ID),
        .I_PEND    (I_PEND),
        .I_MASK    (I_MASK)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_first_active();
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && m_mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] pack(input bit a [8]);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_update(input logic [7:0] src, input logic we, input logic [7:0] mi,
                                input logic [7:0] clr, input logic ack, input logic reti,
                                input logic rst);
        int  s;
        bit  took;
        bit  ev;
        bit  edge_ch;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_mask[i] = 1'b0;
            end
            m_busy = 1'b0;
            m_svc  = 0;
            return;
        end
        s    = m_first_active();
        took = !m_busy && ack && (s >= 0);
        for (int i = 0; i < 8; i++) begin
            edge_ch = EDGE_CFG[i];
            ev = edge_ch ? (src[i] && !m_prev[i]) : src[i];
            if (ev)                                m_pend[i] = 1'b1;
            else if (clr[i] || (took && i == s))   m_pend[i] = 1'b0;
            m_prev[i] = src[i];
            if (we) m_mask[i] = mi[i];
        end
        if (took) begin
            m_busy = 1'b1;
            m_svc  = s;
        end else if (m_busy && reti) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic tick(input logic [7:0] src, input logic we, input logic [7:0] mi,
                        input logic [7:0] clr, input logic ack, input logic reti,
                        input logic rst);
        int s;
        I_SRC = src; I_MASK_WE = we; I_MASK_IN = mi; I_SW_CLR = clr;
        I_ACK = ack; I_RETI = reti; I_RST = rst;
        @(posedge I_CLK);
        model_update(src, we, mi, clr, ack, reti, rst);
        #1;
        s = m_first_active();
        chk("model_out",  32'(I_OUT),  32'(!m_busy && s >= 0));
        chk("model_id",   32'(I_ID),   m_busy ? 32'(m_svc) : (s >= 0 ? 32'(s) : 32'd0));
        chk("model_pend", 32'(I_PEND), 32'(pack(m_pend)));
        chk("model_mask", 32'(I_MASK), 32'(pack(m_mask)));
    endtask

    initial begin
        logic [7:0] r_src;
        logic [7:0] r_clr;

        // Reset state
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_out",  32'(I_OUT),  32'd0);
        chk("rst_id",   32'(I_ID),   32'd0);
        chk("rst_pend", 32'(I_PEND), 32'd0);
        chk("rst_mask", 32'(I_MASK), 32'd0);

        // Single pulse on channel 5
        tick(8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(8'h20, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("p5_pend", 32'(I_PEND), 32'h20);
        chk("p5_out",  32'(I_OUT),  32'd1);
        chk("p5_id",   32'(I_ID),   32'd5);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("p5_done_out", 32'(I_OUT), 32'd0);

        // Channels 2 and 6: priority, ACK, RETI
        tick(8'h44, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("pri_id", 32'(I_ID), 32'd2);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("ack_pend", 32'(I_PEND), 32'h40);
        chk("ack_out",  32'(I_OUT),  32'd0);
        chk("ack_id",   32'(I_ID),   32'd2);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("reti_out", 32'(I_OUT), 32'd1);
        chk("reti_id",  32'(I_ID),  32'd6);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

        // Edge channel 3 held high for 10 cycles
        tick(8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(8'h08, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick(8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("edge_pend", 32'(I_PEND), 32'h00);
        chk("edge_out",  32'(I_OUT),  32'd0);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Level channel 1 held high
        tick(8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(8'h02, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("lvl_svc_pend", 32'(I_PEND), 32'h02);
        for (int k = 0; k < 7; k++) tick(8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("lvl_out", 32'(I_OUT), 32'd1);
        chk("lvl_id",  32'(I_ID),  32'd1);
        tick(8'h00, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("lvl_clr_pend", 32'(I_PEND), 32'h00);

        // Masked channel 4 stays pending, then unmasked
        tick(8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(8'h10, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("msk_out",  32'(I_OUT),  32'd0);
        chk("msk_pend", 32'(I_PEND), 32'h10);
        tick(8'h00, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("unmsk_out", 32'(I_OUT), 32'd1);
        chk("unmsk_id",  32'(I_ID),  32'd4);
        tick(8'h00, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);

        // Set beats software clear on channel 7
        tick(8'h80, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
        chk("setwin_pend", 32'(I_PEND), 32'h80);
        tick(8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("ch7_id", 32'(I_ID), 32'd7);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("svc_latch_pend", 32'(I_PEND), 32'h01);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("ackreti_pend", 32'(I_PEND), 32'h01);
        chk("ackreti_out",  32'(I_OUT),  32'd1);
        chk("ackreti_id",   32'(I_ID),   32'd0);

        // Reset while in service with pending bits set
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_pend", 32'(I_PEND), 32'h0F);
        tick(8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("svc_rst_out",  32'(I_OUT),  32'd0);
        chk("svc_rst_id",   32'(I_ID),   32'd0);
        chk("svc_rst_pend", 32'(I_PEND), 32'h00);
        chk("svc_rst_mask", 32'(I_MASK), 32'h00);

        // Randomized run against the model
        for (int k = 0; k < 400; k++) begin
            r_src = 8'($urandom) & 8'($urandom);
            r_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
            tick(r_src,
                 ($urandom_range(0, 7) == 0),
                 8'($urandom),
                 r_clr,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
